lfsr_seq_checker: RTL and testbench
===================================

// Module: lfsr_seq_checker
// PURPOSE
//  Downstream monitor for the 4-bit LFSR counter (polynomial x^4+x^3+1, shift-left, feedback into bit0).
//  Samples the LFSR's cnt_out each valid cycle and predicts the next state. It reports lock, mismatch
//  errors, a stuck-at-zero state and the measured sequence period, for on-chip BIST of the generator.
// PARAMETERS
//  LOCK_CNT    4   consecutive correct transitions needed to enter LOCK (1..15)
//  UNLOCK_CNT  2   consecutive mismatches in LOCK that force return to HUNT (1..15)
//  ERR_W       8   width of saturating error counter
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  sync_rst    in   1      synchronous reset, active-high
//  in_vld      in   1      in_data is a new LFSR sample this cycle
//  in_data     in   4      LFSR state (cnt_out of the generator)
//  clr_err     in   1      one-cycle pulse: clears err_cnt and stuck_zero
//  locked      out  1      checker is in LOCK state
//  err_pulse   out  1      one-cycle pulse: mismatch detected while in LOCK
//  err_cnt     out  ERR_W  count of LOCK mismatches, saturates at all-ones
//  stuck_zero  out  1      sticky: an all-zero sample was seen (illegal LFSR state)
//  period      out  8      valid samples between successive 4'hF samples, saturates at 255
//  period_vld  out  1      one-cycle pulse: period updated
// BEHAVIOUR
//  - Reset (sync_rst=1 at edge): state=HUNT; all outputs, prev, counters = 0. Reset overrides all other inputs.
//  - Prediction: nxt(p) = {p[2:0], p[3]^p[2]}. Legal cycle from 4'hF (period 15):
//    F,E,C,8,1,2,4,9,3,6,D,A,5,B,7,F.
//  - in_vld=0: no state/counter/prev change; pulses deassert.
//  - On every valid sample, prev <= in_data (re-anchors prediction on real data). match = (in_data == nxt(prev)).
//  - All outputs are registered. Each takes effect in the cycle after the sampling edge (latency 1).
//  - FSM states HUNT / SYNC / LOCK:
//    HUNT: valid nonzero sample -> SYNC, good_cnt=0. Valid zero sample -> stay HUNT, stuck_zero=1.
//    SYNC: match -> good_cnt++. When good_cnt reaches LOCK_CNT -> LOCK, bad_cnt=0.
//          A nonzero mismatch -> good_cnt=0, stay SYNC. A zero sample -> HUNT, stuck_zero=1.
//    LOCK: match -> bad_cnt=0. A mismatch -> err_pulse=1, err_cnt+1 (saturating), bad_cnt++.
//          When bad_cnt reaches UNLOCK_CNT -> HUNT. A zero sample counts as a mismatch, also sets
//          stuck_zero=1 and goes directly to HUNT.
//  - locked = (state==LOCK). It deasserts the cycle after leaving LOCK.
//  - clr_err together with an error in the same cycle: clear first, then count, so err_cnt=1 and
//    stuck_zero reflects the current sample only.
//  - Period, measured only in LOCK:
//    - The first 4'hF sample in LOCK arms the measurement and sets per_cnt=1.
//    - Each later valid non-F sample increments per_cnt (saturating at 255).
//    - The next 4'hF sample sets period<=per_cnt and period_vld=1, then per_cnt=1.
//    - Leaving LOCK disarms the measurement. The period output holds its last value.
//  - A generator async reset (in_data=0) is seen as stuck_zero. Recovery is automatic once nonzero
//    samples resume.
// TESTING
//  1. Reset, then valid F,E,C,8,1 -> locked=1 the cycle after the 1 sample; err_cnt=0.
//  2. Locked, run full cycle from F back to F -> period=15, period_vld pulse exactly once per 15 samples.
//  3. Locked, inject one wrong sample (expect 2, drive 3) -> err_pulse once, err_cnt=1, locked stays 1.
//     Two consecutive bad samples -> locked=0, state HUNT.
//  4. Drive 0 while locked -> stuck_zero=1, err_cnt+1, locked=0. Then clr_err -> stuck_zero=0, err_cnt=0.
//  5. Toggle in_vld low for 3 cycles mid-sequence -> no errors, period unchanged (15). Preload err_cnt
//     to 255 and inject an error -> stays 255.
//  6. Assert sync_rst mid-LOCK together with clr_err and a bad sample -> next cycle all outputs 0,
//     state HUNT.

Source files
------------

// File: rtl/lfsr_seq_checker_if.sv
// lfsr_seq_checker_if
// Bundles the sample stream and the status outputs of the LFSR sequence checker.
//   master : drives in_vld / in_data / clr_err, observes the status outputs
//   slave  : the checker itself
// Signals:
//   in_vld      new LFSR sample this cycle
//   in_data     4-bit LFSR state
//   clr_err     one-cycle pulse clearing err_cnt and stuck_zero
//   locked      checker is in LOCK
//   err_pulse   one-cycle pulse on a mismatch while locked
//   err_cnt     saturating count of mismatches while locked
//   stuck_zero  sticky flag: an all-zero sample was seen
//   period      samples between successive 4'hF samples (saturating)
//   period_vld  one-cycle pulse: period updated
interface lfsr_seq_checker_if #(
    parameter int ERR_W = 8
);
    logic             in_vld;
    logic [3:0]       in_data;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             stuck_zero;
    logic [7:0]       period;
    logic             period_vld;

    modport master (
        output in_vld, in_data, clr_err,
        input  locked, err_pulse, err_cnt, stuck_zero, period, period_vld
    );

    modport slave (
        input  in_vld, in_data, clr_err,
        output locked, err_pulse, err_cnt, stuck_zero, period, period_vld
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker
// Monitors the output of a 4-bit LFSR (x^4+x^3+1, shift-left, feedback into bit0).
// Each valid sample is compared against the prediction from the previous sample.
// Reports lock, mismatch errors, an illegal all-zero state and the sequence period.
// Ports:
//   clk       rising-edge clock
//   sync_rst  synchronous active-high reset
//   bus       lfsr_seq_checker_if slave modport (sample input and status outputs)
// All outputs are registered and reflect a sample one cycle after its sampling edge.
module lfsr_seq_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic                clk,
    input  logic                sync_rst,
    lfsr_seq_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LIM   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_LIM = 4'(UNLOCK_CNT);

    state_t           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    logic             armed_q, armed_d;
    logic [7:0]       per_q, per_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             stuck_q, stuck_d;
    logic [7:0]       period_q, period_d;
    logic             period_vld_q, period_vld_d;

    logic             is_zero;
    logic             is_f;
    logic             match;

    function automatic logic [3:0] lfsr_next(input logic [3:0] p);
        return {p[2:0], p[3] ^ p[2]};
    endfunction

    assign is_zero = (bus.in_data == 4'h0);
    assign is_f    = (bus.in_data == 4'hF);
    assign match   = (bus.in_data == lfsr_next(prev_q));

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q      <= HUNT;
            prev_q       <= '0;
            good_q       <= '0;
            bad_q        <= '0;
            armed_q      <= 1'b0;
            per_q        <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_cnt_q    <= '0;
            stuck_q      <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            armed_q      <= armed_d;
            per_q        <= per_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_cnt_q    <= err_cnt_d;
            stuck_q      <= stuck_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
        end
    end

    // clr_err is applied before any error of the same cycle, so a
    // simultaneous clear and error leaves err_cnt at 1 and stuck_zero set
    // only by the current sample.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        bad_d        = bad_q;
        armed_d      = armed_q;
        per_d        = per_q;
        err_pulse_d  = 1'b0;
        err_cnt_d    = bus.clr_err ? '0 : err_cnt_q;
        stuck_d      = bus.clr_err ? 1'b0 : stuck_q;
        period_d     = period_q;
        period_vld_d = 1'b0;

        if (bus.in_vld) begin
            // Re-anchor the prediction on real data every sample.
            prev_d = bus.in_data;
            if (is_zero) begin
                stuck_d = 1'b1;
            end

            case (state_q)
                HUNT: begin
                    if (!is_zero) begin
                        state_d = SYNC;
                        good_d  = '0;
                    end
                end
                SYNC: begin
                    if (is_zero) begin
                        state_d = HUNT;
                    end else if (match) begin
                        if (good_q + 4'd1 == LOCK_LIM) begin
                            state_d = LOCK;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCK: begin
                    if (match && !is_zero) begin
                        bad_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (!(&err_cnt_d)) begin
                            err_cnt_d = err_cnt_d + 1'b1;
                        end
                        if (is_zero || (bad_q + 4'd1 == UNLOCK_LIM)) begin
                            state_d = HUNT;
                        end else begin
                            bad_d = bad_q + 4'd1;
                        end
                    end

                    // Period runs from one 4'hF to the next; the first F only arms it.
                    if (state_d == LOCK) begin
                        if (is_f) begin
                            if (armed_q) begin
                                period_d     = per_q;
                                period_vld_d = 1'b1;
                            end
                            armed_d = 1'b1;
                            per_d   = 8'd1;
                        end else if (armed_q && per_q != 8'hFF) begin
                            per_d = per_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase

            if (state_d != LOCK) begin
                armed_d = 1'b0;
            end
        end

        locked_d = (state_d == LOCK);
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.stuck_zero = stuck_q;
    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker
// Directed self-checking bench for lfsr_seq_checker. Inputs change 1 time unit
// after a rising edge and outputs are sampled there too, away from the edge.
module tb_lfsr_seq_checker;

    logic clk;
    logic sync_rst;
    int   tests;
    int   fails;

    lfsr_seq_checker_if #(.ERR_W(8)) bus ();

    lfsr_seq_checker #(
        .LOCK_CNT   (4),
        .UNLOCK_CNT (2),
        .ERR_W      (8)
    ) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Legal sequence starting from 4'hF.
    logic [3:0] seq [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                             4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

    function automatic logic [3:0] lfsrNext(input logic [3:0] p);
        return {p[2:0], p[3] ^ p[2]};
    endfunction

    // Drive one cycle of inputs, then step to just after the next rising edge.
    task automatic applyStimulus(input logic vld, input logic [3:0] data, input logic clr);
        bus.in_vld  = vld;
        bus.in_data = data;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
        bus.in_vld  = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    int         pulses;
    logic [3:0] lprev;
    logic [3:0] nx;
    logic [3:0] wrong;

    initial begin
        tests       = 0;
        fails       = 0;
        sync_rst    = 1'b1;
        bus.in_vld  = 1'b0;
        bus.in_data = 4'h0;
        bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sync_rst = 1'b0;

        checkOutput("rst_locked", 32'(bus.locked), 0);
        checkOutput("rst_err_cnt", 32'(bus.err_cnt), 0);
        checkOutput("rst_stuck", 32'(bus.stuck_zero), 0);
        checkOutput("rst_period", 32'(bus.period), 0);
        checkOutput("rst_period_vld", 32'(bus.period_vld), 0);
        checkOutput("rst_err_pulse", 32'(bus.err_pulse), 0);

        // Acquire lock: F,E,C,8 leaves it unlocked, the 1 sample locks.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq[i], 1'b0);
        checkOutput("t1_not_yet_locked", 32'(bus.locked), 0);
        applyStimulus(1'b1, seq[4], 1'b0);
        checkOutput("t1_locked", 32'(bus.locked), 1);
        checkOutput("t1_err_cnt", 32'(bus.err_cnt), 0);

        // First F in LOCK only arms; the next F reports period 15.
        for (int i = 5; i < 15; i++) applyStimulus(1'b1, seq[i], 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0);
        checkOutput("t2_arm_no_pulse", 32'(bus.period_vld), 0);
        pulses = 0;
        for (int i = 1; i < 15; i++) begin
            applyStimulus(1'b1, seq[i], 1'b0);
            if (bus.period_vld) pulses++;
        end
        checkOutput("t2_no_early_pulse", 32'(pulses), 0);
        applyStimulus(1'b1, 4'hF, 1'b0);
        checkOutput("t2_period_vld", 32'(bus.period_vld), 1);
        checkOutput("t2_period", 32'(bus.period), 15);
        applyStimulus(1'b1, 4'hE, 1'b0);
        checkOutput("t2_pulse_one_cycle", 32'(bus.period_vld), 0);

        // Single wrong sample (3 where 2 expected) then re-anchored match.
        applyStimulus(1'b1, 4'hC, 1'b0);
        applyStimulus(1'b1, 4'h8, 1'b0);
        applyStimulus(1'b1, 4'h1, 1'b0);
        applyStimulus(1'b1, 4'h3, 1'b0);
        checkOutput("t3_err_pulse", 32'(bus.err_pulse), 1);
        checkOutput("t3_err_cnt1", 32'(bus.err_cnt), 1);
        checkOutput("t3_still_locked", 32'(bus.locked), 1);
        applyStimulus(1'b1, 4'h6, 1'b0);
        checkOutput("t3_pulse_cleared", 32'(bus.err_pulse), 0);
        checkOutput("t3_locked_after_match", 32'(bus.locked), 1);
        // Two consecutive mismatches (5 for D, then 3 for B) unlock.
        applyStimulus(1'b1, 4'h5, 1'b0);
        checkOutput("t3_first_bad_locked", 32'(bus.locked), 1);
        applyStimulus(1'b1, 4'h3, 1'b0);
        checkOutput("t3_unlocked", 32'(bus.locked), 0);
        checkOutput("t3_err_cnt3", 32'(bus.err_cnt), 3);
        checkOutput("t3_period_held", 32'(bus.period), 15);

        // Zero sample while locked.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, seq[i], 1'b0);
        checkOutput("t4_relocked", 32'(bus.locked), 1);
        applyStimulus(1'b1, 4'h0, 1'b0);
        checkOutput("t4_stuck", 32'(bus.stuck_zero), 1);
        checkOutput("t4_err_cnt4", 32'(bus.err_cnt), 4);
        checkOutput("t4_zero_pulse", 32'(bus.err_pulse), 1);
        checkOutput("t4_zero_unlock", 32'(bus.locked), 0);
        applyStimulus(1'b0, 4'h0, 1'b1);
        checkOutput("t4_clr_stuck", 32'(bus.stuck_zero), 0);
        checkOutput("t4_clr_err_cnt", 32'(bus.err_cnt), 0);

        // Idle gap of 3 cycles mid-sequence must not disturb the period.
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, seq[i], 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0);
        for (int i = 1; i < 6; i++) applyStimulus(1'b1, seq[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'h7, 1'b0);
            checkOutput("t5_idle_no_err", 32'(bus.err_pulse), 0);
        end
        for (int i = 6; i < 15; i++) applyStimulus(1'b1, seq[i], 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0);
        checkOutput("t5_period_vld", 32'(bus.period_vld), 1);
        checkOutput("t5_period", 32'(bus.period), 15);
        checkOutput("t5_err_cnt", 32'(bus.err_cnt), 0);
        checkOutput("t5_locked", 32'(bus.locked), 1);

        // Preload err_cnt to 255: wrong sample then re-anchored match, repeated.
        lprev = 4'hF;
        for (int i = 0; i < 255; i++) begin
            nx    = lfsrNext(lprev);
            wrong = (nx == 4'h1) ? 4'h2 : (nx ^ 4'h1);
            applyStimulus(1'b1, wrong, 1'b0);
            lprev = lfsrNext(wrong);
            applyStimulus(1'b1, lprev, 1'b0);
        end
        checkOutput("t5_preload_255", 32'(bus.err_cnt), 255);
        checkOutput("t5_preload_locked", 32'(bus.locked), 1);
        nx    = lfsrNext(lprev);
        wrong = (nx == 4'h1) ? 4'h2 : (nx ^ 4'h1);
        applyStimulus(1'b1, wrong, 1'b0);
        checkOutput("t5_sat_pulse", 32'(bus.err_pulse), 1);
        checkOutput("t5_sat_255", 32'(bus.err_cnt), 255);
        lprev = lfsrNext(wrong);
        applyStimulus(1'b1, lprev, 1'b0);

        // Clear and error in the same cycle: clear first, then count.
        nx    = lfsrNext(lprev);
        wrong = (nx == 4'h1) ? 4'h2 : (nx ^ 4'h1);
        applyStimulus(1'b1, wrong, 1'b1);
        checkOutput("t5_clr_and_err", 32'(bus.err_cnt), 1);
        checkOutput("t5_clr_stuck_clear", 32'(bus.stuck_zero), 0);
        lprev = lfsrNext(wrong);
        applyStimulus(1'b1, lprev, 1'b0);
        checkOutput("t6_pre_locked", 32'(bus.locked), 1);

        // Reset mid-LOCK with clr_err and a bad sample: reset wins.
        sync_rst = 1'b1;
        applyStimulus(1'b1, 4'h0, 1'b1);
        sync_rst = 1'b0;
        checkOutput("t6_locked", 32'(bus.locked), 0);
        checkOutput("t6_err_cnt", 32'(bus.err_cnt), 0);
        checkOutput("t6_stuck", 32'(bus.stuck_zero), 0);
        checkOutput("t6_err_pulse", 32'(bus.err_pulse), 0);
        checkOutput("t6_period", 32'(bus.period), 0);
        checkOutput("t6_period_vld", 32'(bus.period_vld), 0);

        // Zero in HUNT sets stuck_zero but is not a counted error.
        applyStimulus(1'b1, 4'h0, 1'b0);
        checkOutput("t6_hunt_zero_stuck", 32'(bus.stuck_zero), 1);
        checkOutput("t6_hunt_zero_no_err", 32'(bus.err_cnt), 0);

        // From HUNT, the fifth matching sample locks.
        applyStimulus(1'b1, 4'h1, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0);
        applyStimulus(1'b1, 4'h4, 1'b0);
        applyStimulus(1'b1, 4'h9, 1'b0);
        checkOutput("t6_hunt_not_locked", 32'(bus.locked), 0);
        applyStimulus(1'b1, 4'h3, 1'b0);
        checkOutput("t6_hunt_relock", 32'(bus.locked), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
